// File: rtl/register_bank.sv
//------------------------------------------------------------------------------
// Module   : register_bank
// Purpose  : Bank of DEPTH general-purpose registers, WIDTH bits each, sharing
//            one 8-function operation set (FunSel). Writes are one-hot
//            multi-select. There are two independent combinational read ports
//            with zero detect, and a sticky wrap flag per register that
//            records increment/decrement overflow.
// Ports    : Clock   - sole clock, rising edge
//            Reset   - synchronous, active-low
//            I       - write data [WIDTH]
//            FunSel  - operation applied to every enabled register [3]
//            RegSel  - per-register write enable [DEPTH]
//            FlagClr - per-register wrap-flag clear [DEPTH]
//            OutASel - read select, port A [SW]
//            OutBSel - read select, port B [SW]
//            OutA    - register OutASel, or 0 if out of range [WIDTH]
//            OutB    - register OutBSel, or 0 if out of range [WIDTH]
//            ZeroA   - OutA == 0
//            ZeroB   - OutB == 0
//            Wrap    - sticky wrap flag per register [DEPTH]
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module register_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int H    = WIDTH / 2,
  localparam int SW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [DEPTH-1:0] RegSel,
  input  logic [DEPTH-1:0] FlagClr,
  input  logic [SW-1:0]    OutASel,
  input  logic [SW-1:0]    OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             ZeroA,
  output logic             ZeroB,
  output logic [DEPTH-1:0] Wrap
);

  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_CLR  = 3'b011;
  localparam logic [2:0] FS_WLCH = 3'b100;
  localparam logic [2:0] FS_WLO  = 3'b101;
  localparam logic [2:0] FS_WHI  = 3'b110;
  localparam logic [2:0] FS_WLSX = 3'b111;

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0][WIDTH-1:0] next_q;
  logic [DEPTH-1:0]            wrap_set;
  logic [DEPTH-1:0]            wrap_clr;
  logic [DEPTH-1:0]            wrap_q;

  // Result of FunSel applied to a register value q with write data d.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [WIDTH-1:0] q,
    input logic [2:0]       fs,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] r;
    r = q;
    case (fs)
      FS_DEC:  r = q - WIDTH'(1);
      FS_INC:  r = q + WIDTH'(1);
      FS_LOAD: r = d;
      FS_CLR:  r = '0;
      FS_WLCH: r = {{H{1'b0}}, d[H-1:0]};
      FS_WLO:  r = {q[WIDTH-1:H], d[H-1:0]};
      FS_WHI:  r = {d[H-1:0], q[H-1:0]};
      FS_WLSX: r = {{H{d[H-1]}}, d[H-1:0]};
      default: r = q;
    endcase
    return r;
  endfunction

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_reg
      assign next_q[k] = apply_op(regs[k], FunSel, I);

      // Overflow only on inc of all-ones or dec of zero.
      assign wrap_set[k] = RegSel[k] &
                           (((FunSel == FS_INC) && (regs[k] == {WIDTH{1'b1}})) ||
                            ((FunSel == FS_DEC) && (regs[k] == '0)));

      // Load/clear of the register discards its overflow history.
      assign wrap_clr[k] = RegSel[k] & ((FunSel == FS_LOAD) || (FunSel == FS_CLR));
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      regs   <= '0;
      wrap_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (RegSel[k]) begin
          regs[k] <= next_q[k];
        end
        // A set in the same cycle as any clear source wins.
        if (wrap_set[k]) begin
          wrap_q[k] <= 1'b1;
        end else if (wrap_clr[k] || FlagClr[k]) begin
          wrap_q[k] <= 1'b0;
        end
      end
    end
  end

  // Select decode by comparison so an out-of-range select falls through to 0
  // without indexing past the array.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (OutASel == SW'(k)) OutA = regs[k];
      if (OutBSel == SW'(k)) OutB = regs[k];
    end
  end

  assign ZeroA = (OutA == '0);
  assign ZeroB = (OutB == '0);
  assign Wrap  = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_register_bank.sv
//------------------------------------------------------------------------------
// Module   : tb_register_bank
// Purpose  : Directed self-checking bench for register_bank (WIDTH=16,
//            DEPTH=4) with hand-computed expected values.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_register_bank;

  logic        Clock;
  logic        Reset;
  logic [15:0] I;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  FlagClr;
  logic [1:0]  OutASel;
  logic [1:0]  OutBSel;
  logic [15:0] OutA;
  logic [15:0] OutB;
  logic        ZeroA;
  logic        ZeroB;
  logic [3:0]  Wrap;

  int checks   = 0;
  int failures = 0;

  register_bank #(.WIDTH(16), .DEPTH(4)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .I       (I),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .FlagClr (FlagClr),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .OutA    (OutA),
    .OutB    (OutB),
    .ZeroA   (ZeroA),
    .ZeroB   (ZeroB),
    .Wrap    (Wrap)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance past the next rising edge; inputs are then changed away from it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read one register through port A.
  task automatic chk_reg(input string tag, input logic [1:0] k, input logic [15:0] exp);
    OutASel = k;
    #1;
    chk(tag, {16'h0, OutA}, {16'h0, exp});
  endtask

  initial begin
    Reset   = 1'b0;
    I       = 16'h0000;
    FunSel  = 3'b001;
    RegSel  = 4'b1111;
    FlagClr = 4'b0000;
    OutASel = 2'd0;
    OutBSel = 2'd1;

    // Reset held two cycles while an increment of all registers is presented.
    tick();
    tick();
    chk("rst_zeroa", {31'h0, ZeroA}, 32'h1);
    chk("rst_zerob", {31'h0, ZeroB}, 32'h1);
    chk("rst_wrap", {28'h0, Wrap}, 32'h0);
    chk_reg("rst_r0", 2'd0, 16'h0000);
    chk_reg("rst_r1", 2'd1, 16'h0000);
    chk_reg("rst_r2", 2'd2, 16'h0000);
    chk_reg("rst_r3", 2'd3, 16'h0000);

    // Release: the next edge increments all four.
    Reset = 1'b1;
    tick();
    RegSel = 4'b0000;
    chk_reg("inc_r0", 2'd0, 16'h0001);
    chk_reg("inc_r3", 2'd3, 16'h0001);
    chk("inc_wrap", {28'h0, Wrap}, 32'h0);

    // Half-word operations on register 2.
    RegSel = 4'b0100; FunSel = 3'b010; I = 16'h1234; tick();
    chk_reg("r2_load", 2'd2, 16'h1234);
    FunSel = 3'b101; I = 16'h00AB; tick();
    chk_reg("r2_wlo", 2'd2, 16'h12AB);
    FunSel = 3'b110; I = 16'h00CD; tick();
    chk_reg("r2_whi", 2'd2, 16'hCDAB);
    FunSel = 3'b111; I = 16'h0080; tick();
    chk_reg("r2_sext", 2'd2, 16'hFF80);
    FunSel = 3'b100; I = 16'hFF80; tick();
    chk_reg("r2_wlch", 2'd2, 16'h0080);

    // Wrap on register 1.
    RegSel = 4'b0010; FunSel = 3'b010; I = 16'hFFFF; tick();
    chk_reg("r1_load", 2'd1, 16'hFFFF);
    FunSel = 3'b001; tick();
    RegSel = 4'b0000;
    chk_reg("r1_incwrap", 2'd1, 16'h0000);
    chk("r1_zeroa", {31'h0, ZeroA}, 32'h1);
    chk("r1_wrapset", {28'h0, Wrap}, 32'h2);
    RegSel = 4'b0010; FunSel = 3'b000; tick();
    RegSel = 4'b0000;
    chk_reg("r1_decwrap", 2'd1, 16'hFFFF);
    chk("r1_wrapstay", {28'h0, Wrap}, 32'h2);
    FlagClr = 4'b0010; tick();
    FlagClr = 4'b0000;
    chk("r1_flagclr", {28'h0, Wrap}, 32'h0);
    chk_reg("r1_hold", 2'd1, 16'hFFFF);

    // Register 3: set beats FlagClr in the same cycle, then load clears.
    RegSel = 4'b1000; FunSel = 3'b011; tick();
    chk_reg("r3_clear", 2'd3, 16'h0000);
    FunSel = 3'b000; FlagClr = 4'b1000; tick();
    FlagClr = 4'b0000;
    chk_reg("r3_dec", 2'd3, 16'hFFFF);
    chk("r3_setwins", {28'h0, Wrap}, 32'h8);
    FunSel = 3'b010; I = 16'h0005; tick();
    chk_reg("r3_load", 2'd3, 16'h0005);
    chk("r3_loadclr", {28'h0, Wrap}, 32'h0);

    // Multi-select load of registers 0 and 2.
    RegSel = 4'b0101; FunSel = 3'b010; I = 16'hBEEF; tick();
    RegSel = 4'b0000;
    OutASel = 2'd0; OutBSel = 2'd2; #1;
    chk("multi_outa", {16'h0, OutA}, 32'hBEEF);
    chk("multi_outb", {16'h0, OutB}, 32'hBEEF);
    chk("multi_zerob", {31'h0, ZeroB}, 32'h0);
    chk_reg("multi_r1", 2'd1, 16'hFFFF);
    chk_reg("multi_r3", 2'd3, 16'h0005);

    // Read during write: old value until the edge, new value after.
    OutASel = 2'd0; RegSel = 4'b0001; FunSel = 3'b010; I = 16'h1111; #1;
    chk("rdw_before", {16'h0, OutA}, 32'hBEEF);
    tick();
    chk("rdw_after", {16'h0, OutA}, 32'h1111);

    // No register enabled: nothing changes.
    RegSel = 4'b0000; FunSel = 3'b011; tick();
    chk_reg("nosel_r0", 2'd0, 16'h1111);
    chk_reg("nosel_r1", 2'd1, 16'hFFFF);
    chk_reg("nosel_r2", 2'd2, 16'hBEEF);
    chk_reg("nosel_r3", 2'd3, 16'h0005);

    // Reset mid-sequence discards the presented load.
    Reset = 1'b0; RegSel = 4'b1111; FunSel = 3'b010; I = 16'hAAAA; tick();
    Reset = 1'b1; RegSel = 4'b0000;
    chk_reg("midrst_r0", 2'd0, 16'h0000);
    chk_reg("midrst_r2", 2'd2, 16'h0000);

    // Decrement of zero on register 0 wraps to all ones.
    RegSel = 4'b0001; FunSel = 3'b000; tick();
    RegSel = 4'b0000;
    chk_reg("r0_decwrap", 2'd0, 16'hFFFF);
    chk("r0_wrap", {28'h0, Wrap}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
